// File: rtl/freq_pkg.sv
// freq_pkg -- shared definitions for the frequency-sweep block and the
// SWIPT control blocks that sit next to it.
//   sweep_state_t : sweep FSM state encoding
//   *_DEF         : default parameter values for freq_sweep / adc_avg
package freq_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      SETTLE     = 3'd1,
      ACCUM      = 3'd2,
      EVAL       = 3'd3,
      FINE_SETUP = 3'd4,
      DONE       = 3'd5
   } sweep_state_t;

   localparam int FREQ_W_DEF     = 20;
   localparam int ADC_W_DEF      = 12;
   localparam int SETTLE_W_DEF   = 24;
   localparam int AVG_LOG2_DEF   = 2;
   localparam int FINE_SHIFT_DEF = 3;

endpackage

// File: rtl/freq_sweep_adc_avg.sv
// adc_avg -- averages 2^AVG_LOG2 rectified-power samples.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clear      : drop any partial sum and restart the sample count
//   sample_en  : add adc to the running sum this cycle
//   adc        : sample value
//   avg        : registered average of the last complete window
//   avg_valid  : one-cycle pulse, the cycle after the window completes
module adc_avg
   import freq_pkg::*;
#(
   parameter int ADC_W    = ADC_W_DEF,
   parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             sample_en,
   input  logic [ADC_W-1:0] adc,
   output logic [ADC_W-1:0] avg,
   output logic             avg_valid
);

   localparam int ACC_W = ADC_W + AVG_LOG2;
   // Keep at least one count bit so AVG_LOG2 = 0 still elaborates.
   localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_sum;
   logic [CNT_W-1:0] cnt;

   assign acc_sum = acc + ACC_W'(adc);

   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= '0;
         cnt       <= '0;
         avg       <= '0;
         avg_valid <= 1'b0;
      end else begin
         avg_valid <= 1'b0;
         if (clear) begin
            acc <= '0;
            cnt <= '0;
         end else if (sample_en) begin
            if (cnt == CNT_LAST) begin
               // Window complete: publish the mean and restart.
               avg       <= ADC_W'(acc_sum >> AVG_LOG2);
               avg_valid <= 1'b1;
               acc       <= '0;
               cnt       <= '0;
            end else begin
               acc <= acc_sum;
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/freq_sweep.sv
// freq_sweep -- coarse (and optional fine) drive-frequency sweep that looks
// for the frequency giving the highest averaged rectified power.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   enable                : link alive; low forces IDLE
//   start                 : level request; falling while busy aborts
//   fine_en               : run a refinement pass around the coarse best
//   adc, adc_valid        : rectified-power sample and strobe
//   cfg_start/stop/step   : sweep range and step (latched at start)
//   cfg_settle            : settle cycles per point (0 behaves as 1)
//   freq_out              : drive frequency
//   best_freq, best_adc   : best point found so far and its average
//   busy, done            : sweep running / sweep finished (held until start low)
module freq_sweep
   import freq_pkg::*;
#(
   parameter int FREQ_W     = FREQ_W_DEF,
   parameter int ADC_W      = ADC_W_DEF,
   parameter int SETTLE_W   = SETTLE_W_DEF,
   parameter int AVG_LOG2   = AVG_LOG2_DEF,
   parameter int FINE_SHIFT = FINE_SHIFT_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                start,
   input  logic                fine_en,
   input  logic [ADC_W-1:0]    adc,
   input  logic                adc_valid,
   input  logic [FREQ_W-1:0]   cfg_start,
   input  logic [FREQ_W-1:0]   cfg_stop,
   input  logic [FREQ_W-1:0]   cfg_step,
   input  logic [SETTLE_W-1:0] cfg_settle,
   output logic [FREQ_W-1:0]   freq_out,
   output logic [FREQ_W-1:0]   best_freq,
   output logic [ADC_W-1:0]    best_adc,
   output logic                busy,
   output logic                done
);

   sweep_state_t state, state_next;

   logic [FREQ_W-1:0]   freq_r;
   logic [FREQ_W-1:0]   start_r;
   logic [FREQ_W-1:0]   stop_r;
   logic [FREQ_W-1:0]   step_r;
   logic [SETTLE_W-1:0] settle_r;
   logic [SETTLE_W-1:0] settle_cnt;
   logic                fine_pass;
   logic [FREQ_W-1:0]   best_freq_r;
   logic [ADC_W-1:0]    best_adc_r;

   logic [ADC_W-1:0]    avg;
   logic                avg_valid;

   logic [FREQ_W:0]     nxt_ext;
   logic                more_points;
   logic                better;
   logic [FREQ_W-1:0]   best_freq_eval;
   logic                go_fine;
   logic                settle_last;

   // A zero step would never advance; it runs as a unit step.
   function automatic logic [FREQ_W-1:0] norm_step(input logic [FREQ_W-1:0] s);
      return (s == '0) ? FREQ_W'(1) : s;
   endfunction

   function automatic logic [FREQ_W-1:0] fine_step(input logic [FREQ_W-1:0] s);
      logic [FREQ_W-1:0] r;
      r = s >> FINE_SHIFT;
      return (r == '0) ? FREQ_W'(1) : r;
   endfunction

   // max(best - step, floor), with subtraction underflow landing on floor.
   function automatic logic [FREQ_W-1:0] clamp_lo(input logic [FREQ_W-1:0] best,
                                                  input logic [FREQ_W-1:0] s,
                                                  input logic [FREQ_W-1:0] floor_v);
      logic [FREQ_W:0] lim;
      lim = {1'b0, floor_v} + {1'b0, s};
      return ({1'b0, best} < lim) ? floor_v : (best - s);
   endfunction

   // min(best + step, ceiling), with addition overflow landing on ceiling.
   function automatic logic [FREQ_W-1:0] clamp_hi(input logic [FREQ_W-1:0] best,
                                                  input logic [FREQ_W-1:0] s,
                                                  input logic [FREQ_W-1:0] ceil_v);
      logic [FREQ_W:0] sum;
      sum = {1'b0, best} + {1'b0, s};
      return (sum > {1'b0, ceil_v}) ? ceil_v : sum[FREQ_W-1:0];
   endfunction

   adc_avg #(
      .ADC_W    (ADC_W),
      .AVG_LOG2 (AVG_LOG2)
   ) u_avg (
      .clk       (clk),
      .rst       (rst),
      .clear     (state == SETTLE),
      // Hold off while the finished window is being handed to the FSM.
      .sample_en ((state == ACCUM) && adc_valid && !avg_valid),
      .adc       (adc),
      .avg       (avg),
      .avg_valid (avg_valid)
   );

   // Next point is computed one bit wider so the top of the range cannot wrap.
   assign nxt_ext        = {1'b0, freq_r} + {1'b0, step_r};
   assign more_points    = (nxt_ext <= {1'b0, stop_r});
   assign better         = (avg > best_adc_r);
   assign best_freq_eval = better ? freq_r : best_freq_r;
   assign go_fine        = !fine_pass && fine_en && (step_r > FREQ_W'(1));
   assign settle_last    = (settle_cnt <= SETTLE_W'(1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state and status decode
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (enable && start) state_next = SETTLE;
         end
         SETTLE: begin
            busy = 1'b1;
            if (settle_last) state_next = ACCUM;
         end
         ACCUM: begin
            busy = 1'b1;
            if (avg_valid) state_next = EVAL;
         end
         EVAL: begin
            busy = 1'b1;
            if (more_points)  state_next = SETTLE;
            else if (go_fine) state_next = FINE_SETUP;
            else              state_next = DONE;
         end
         FINE_SETUP: begin
            busy       = 1'b1;
            state_next = SETTLE;
         end
         DONE: begin
            done = 1'b1;
            if (!start) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      // Link loss, or the request going away mid-sweep, abandons the sweep.
      if (!enable)             state_next = IDLE;
      else if (busy && !start) state_next = IDLE;
   end

   // Working registers and results
   always_ff @(posedge clk) begin
      if (rst) begin
         freq_r      <= '0;
         start_r     <= '0;
         stop_r      <= '0;
         step_r      <= '0;
         settle_r    <= '0;
         settle_cnt  <= '0;
         fine_pass   <= 1'b0;
         best_freq_r <= '0;
         best_adc_r  <= '0;
      end else begin
         case (state)
            IDLE: begin
               freq_r <= cfg_start;
               if (state_next == SETTLE) begin
                  start_r     <= cfg_start;
                  stop_r      <= cfg_stop;
                  step_r      <= norm_step(cfg_step);
                  settle_r    <= cfg_settle;
                  settle_cnt  <= cfg_settle;
                  fine_pass   <= 1'b0;
                  best_freq_r <= cfg_start;
                  best_adc_r  <= '0;
               end
            end
            SETTLE: begin
               if (!settle_last) settle_cnt <= settle_cnt - 1'b1;
            end
            EVAL: begin
               // Strict compare: on a tie the earlier (lower) point is kept.
               if (better) begin
                  best_adc_r  <= avg;
                  best_freq_r <= freq_r;
               end
               if (more_points) begin
                  freq_r     <= nxt_ext[FREQ_W-1:0];
                  settle_cnt <= settle_r;
               end else if (!go_fine) begin
                  freq_r <= best_freq_eval;
               end
            end
            FINE_SETUP: begin
               freq_r     <= clamp_lo(best_freq_r, step_r, start_r);
               stop_r     <= clamp_hi(best_freq_r, step_r, stop_r);
               step_r     <= fine_step(step_r);
               fine_pass  <= 1'b1;
               settle_cnt <= settle_r;
            end
            default: ;
         endcase
         // Any return to IDLE presents the configured start frequency.
         if ((state != IDLE) && (state_next == IDLE)) freq_r <= cfg_start;
      end
   end

   assign freq_out  = freq_r;
   assign best_freq = best_freq_r;
   assign best_adc  = best_adc_r;

endmodule

// File: tb/tb_freq_sweep.sv
// tb_freq_sweep -- self-checking bench for freq_sweep. A per-frequency ADC
// profile drives adc with a random valid pattern; a sweep model computes the
// visited points and the expected best point directly from the sweep rules.
module tb_freq_sweep;

   localparam int FREQ_W   = 20;
   localparam int ADC_W    = 12;
   localparam int SETTLE_W = 24;

   logic                clk = 1'b0;
   logic                rst;
   logic                enable;
   logic                start;
   logic                fine_en;
   logic [ADC_W-1:0]    adc;
   logic                adc_valid;
   logic [FREQ_W-1:0]   cfg_start;
   logic [FREQ_W-1:0]   cfg_stop;
   logic [FREQ_W-1:0]   cfg_step;
   logic [SETTLE_W-1:0] cfg_settle;
   logic [FREQ_W-1:0]   freq_out;
   logic [FREQ_W-1:0]   best_freq;
   logic [ADC_W-1:0]    best_adc;
   logic                busy;
   logic                done;

   freq_sweep #(
      .FREQ_W(FREQ_W), .ADC_W(ADC_W), .SETTLE_W(SETTLE_W),
      .AVG_LOG2(2), .FINE_SHIFT(3)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .start(start), .fine_en(fine_en),
      .adc(adc), .adc_valid(adc_valid),
      .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step),
      .cfg_settle(cfg_settle),
      .freq_out(freq_out), .best_freq(best_freq), .best_adc(best_adc),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // ADC profile selection: 0 = peak, 1 = tie, 2 = pseudo-random hash.
   int          prof_mode = 0;
   longint      peak      = 0;
   int unsigned seed      = 0;
   bit          drive_valid = 1'b0;

   longint vis[$];
   longint exp_pts[$];
   longint exp_bf;
   int     exp_ba;
   bit     in_run = 1'b0;
   longint last_f = 0;

   function automatic int prof(input longint f);
      longint      d;
      int unsigned h;
      case (prof_mode)
         0: begin
            d = (f > peak) ? (f - peak) : (peak - f);
            return (d >= 3000) ? 0 : int'(3000 - d);
         end
         1: return (f == 100100 || f == 100300) ? 2000 : 500;
         default: begin
            h = 32'(f) * 32'h9E3779B1;
            h = h ^ seed;
            h = h ^ (h >> 15);
            return int'(h & 32'hFFF);
         end
      endcase
   endfunction

   // Constant ADC value per point; the valid strobe is random.
   always @(posedge clk) begin
      #2;
      adc       = 12'(prof(longint'(freq_out)));
      adc_valid = drive_valid && ($urandom_range(0, 3) != 0);
   end

   // Record each new drive frequency seen while the sweep is running.
   always @(posedge clk) begin
      #1;
      if (busy === 1'b1) begin
         if (!in_run || longint'(freq_out) != last_f) begin
            vis.push_back(longint'(freq_out));
            last_f = longint'(freq_out);
         end
         in_run = 1'b1;
      end else begin
         in_run = 1'b0;
      end
   end

   task automatic model_pass(input longint lo, input longint hi, input longint s);
      longint f;
      int     a;
      f = lo;
      forever begin
         a = prof(f);
         if (a > exp_ba) begin
            exp_ba = a;
            exp_bf = f;
         end
         if (exp_pts.size() == 0 || exp_pts[exp_pts.size()-1] != f) exp_pts.push_back(f);
         if (f + s > hi) break;
         f = f + s;
      end
   endtask

   task automatic model_sweep(input longint st, input longint sp, input longint stp, input bit fine);
      longint s, lo, hi, s2;
      s = (stp == 0) ? 1 : stp;
      exp_ba = 0;
      exp_bf = st;
      exp_pts.delete();
      model_pass(st, sp, s);
      if (fine && s > 1) begin
         lo = exp_bf - s;
         if (lo < st) lo = st;
         hi = exp_bf + s;
         if (hi > sp) hi = sp;
         s2 = s >> 3;
         if (s2 < 1) s2 = 1;
         model_pass(lo, hi, s2);
      end
   endtask

   function automatic int seq_diff();
      int n;
      n = (vis.size() > exp_pts.size()) ? vis.size() - exp_pts.size()
                                        : exp_pts.size() - vis.size();
      for (int i = 0; i < vis.size() && i < exp_pts.size(); i++)
         if (vis[i] != exp_pts[i]) n++;
      return n;
   endfunction

   // Drive a sweep request and wait (bounded) for done.
   task automatic run_sweep(input longint st, input longint sp, input longint stp,
                            input int settle, input bit fine, input bit scramble,
                            output bit timeout);
      int cyc;
      cfg_start   = FREQ_W'(st);
      cfg_stop    = FREQ_W'(sp);
      cfg_step    = FREQ_W'(stp);
      cfg_settle  = SETTLE_W'(settle);
      fine_en     = fine;
      drive_valid = 1'b1;
      enable      = 1'b1;
      vis.delete();
      start = 1'b1;
      cyc   = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
         if (scramble && busy) begin
            cfg_start  = FREQ_W'($urandom);
            cfg_stop   = FREQ_W'($urandom);
            cfg_step   = FREQ_W'($urandom);
            cfg_settle = SETTLE_W'($urandom_range(0, 50));
         end
      end while (!done && cyc < 20000);
      timeout = !done;
   endtask

   task automatic release_start();
      start = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b1; start = 1'b1; fine_en = 1'b0;
      cfg_start = 20'd12345; cfg_stop = 20'd12400; cfg_step = 20'd10; cfg_settle = 24'd2;
      repeat (2) @(posedge clk);
      #1;
      total++; if (freq_out !== 20'd0) begin bad++; $display("FAIL reset_freq_out got=%0d want=0", freq_out); end
      total++; if (best_freq !== 20'd0) begin bad++; $display("FAIL reset_best_freq got=%0d want=0", best_freq); end
      total++; if (best_adc !== 12'd0) begin bad++; $display("FAIL reset_best_adc got=%0d want=0", best_adc); end
      total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_flags got busy=%b done=%b want 0 0", busy, done); end
      rst = 1'b0; start = 1'b0;
      @(posedge clk); #1;
      total++; if (freq_out !== 20'd12345) begin bad++; $display("FAIL idle_freq_out got=%0d want=12345", freq_out); end
   endtask

   task automatic test_coarse();
      bit to;
      prof_mode = 0; peak = 100200;
      model_sweep(100000, 100400, 100, 1'b0);
      run_sweep(100000, 100400, 100, 4, 1'b0, 1'b0, to);
      total++; if (to) begin bad++; $display("FAIL coarse_timeout done never rose"); end
      total++; if (best_freq !== 20'd100200) begin bad++; $display("FAIL coarse_best_freq got=%0d want=100200", best_freq); end
      total++; if (best_adc !== 12'd3000) begin bad++; $display("FAIL coarse_best_adc got=%0d want=3000", best_adc); end
      total++; if (vis.size() != 5 || seq_diff() != 0) begin bad++; $display("FAIL coarse_points got=%0d points want=5 (diff=%0d)", vis.size(), seq_diff()); end
      total++; if (freq_out !== best_freq || busy !== 1'b0) begin bad++; $display("FAIL coarse_done_out got freq=%0d busy=%b want freq=%0d busy=0", freq_out, busy, best_freq); end
      release_start();
      total++; if (done !== 1'b0 || freq_out !== 20'd100000) begin bad++; $display("FAIL coarse_release got done=%b freq=%0d want done=0 freq=100000", done, freq_out); end
   endtask

   task automatic test_fine();
      bit to;
      prof_mode = 0; peak = 100237;
      model_sweep(100000, 100400, 100, 1'b1);
      run_sweep(100000, 100400, 100, 4, 1'b1, 1'b0, to);
      total++; if (to) begin bad++; $display("FAIL fine_timeout done never rose"); end
      total++; if (best_freq !== 20'd100232) begin bad++; $display("FAIL fine_best_freq got=%0d want=100232", best_freq); end
      total++; if (best_adc !== 12'd2995) begin bad++; $display("FAIL fine_best_adc got=%0d want=2995", best_adc); end
      total++; if (seq_diff() != 0) begin bad++; $display("FAIL fine_points got=%0d points want=%0d (diff=%0d)", vis.size(), exp_pts.size(), seq_diff()); end
      release_start();
   endtask

   task automatic test_tie();
      bit to;
      prof_mode = 1;
      run_sweep(100000, 100400, 100, 1, 1'b0, 1'b0, to);
      total++; if (to) begin bad++; $display("FAIL tie_timeout done never rose"); end
      total++; if (best_freq !== 20'd100100 || best_adc !== 12'd2000) begin bad++; $display("FAIL tie_best got freq=%0d adc=%0d want 100100 2000", best_freq, best_adc); end
      release_start();
   endtask

   task automatic test_abort();
      int cyc;
      prof_mode = 0; peak = 100200;
      model_sweep(100000, 100100, 100, 1'b0);  // the two points completed before the abort
      cfg_start = 20'd100000; cfg_stop = 20'd100400; cfg_step = 20'd100; cfg_settle = 24'd4;
      fine_en = 1'b0; drive_valid = 1'b1; enable = 1'b1; start = 1'b1;
      cyc = 0;
      do begin @(posedge clk); #1; cyc++; end while (!(busy && freq_out == 20'd100200) && cyc < 5000);
      total++; if (cyc >= 5000) begin bad++; $display("FAIL abort_reach third point never reached"); end
      drive_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      enable = 1'b0;
      @(posedge clk); #1;
      total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL abort_flags got busy=%b done=%b want 0 0", busy, done); end
      total++; if (freq_out !== 20'd100000) begin bad++; $display("FAIL abort_freq_out got=%0d want=100000", freq_out); end
      total++; if (longint'(best_freq) != exp_bf || int'(best_adc) != exp_ba) begin bad++; $display("FAIL abort_best got freq=%0d adc=%0d want %0d %0d", best_freq, best_adc, exp_bf, exp_ba); end
      enable = 1'b1; start = 1'b0; drive_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++; if (busy !== 1'b0 || longint'(best_freq) != exp_bf) begin bad++; $display("FAIL abort_hold got busy=%b best=%0d want busy=0 best=%0d", busy, best_freq, exp_bf); end
      // Start falling mid-sweep: best holds the first point only.
      start = 1'b1;
      cyc = 0;
      do begin @(posedge clk); #1; cyc++; end while (!(busy && freq_out == 20'd100100) && cyc < 5000);
      start = 1'b0;
      @(posedge clk); #1;
      total++; if (busy !== 1'b0 || done !== 1'b0 || best_freq !== 20'd100000 || best_adc !== 12'd2800) begin bad++; $display("FAIL start_abort got busy=%b done=%b best=%0d adc=%0d want 0 0 100000 2800", busy, done, best_freq, best_adc); end
   endtask

   task automatic test_boundaries();
      bit to;
      prof_mode = 2; seed = 32'h1234_5678;
      model_sweep(10, 14, 0, 1'b1);
      run_sweep(10, 14, 0, 0, 1'b1, 1'b0, to);
      total++; if (to || vis.size() != 5 || seq_diff() != 0) begin bad++; $display("FAIL step0_points got=%0d timeout=%b want 5", vis.size(), to); end
      total++; if (longint'(best_freq) != exp_bf || int'(best_adc) != exp_ba) begin bad++; $display("FAIL step0_best got %0d/%0d want %0d/%0d", best_freq, best_adc, exp_bf, exp_ba); end
      release_start();
      model_sweep(0, 20'hFFFFF, 20'h80000, 1'b0);
      run_sweep(0, 20'hFFFFF, 20'h80000, 2, 1'b0, 1'b0, to);
      total++; if (to || vis.size() != 2 || seq_diff() != 0) begin bad++; $display("FAIL nowrap_points got=%0d timeout=%b want 2", vis.size(), to); end
      total++; if (longint'(best_freq) != exp_bf || int'(best_adc) != exp_ba) begin bad++; $display("FAIL nowrap_best got %0d/%0d want %0d/%0d", best_freq, best_adc, exp_bf, exp_ba); end
      release_start();
      model_sweep(500, 100, 10, 1'b0);
      run_sweep(500, 100, 10, 1, 1'b0, 1'b0, to);
      total++; if (to || vis.size() != 1 || best_freq !== 20'd500 || int'(best_adc) != exp_ba) begin bad++; $display("FAIL inverted_range got pts=%0d best=%0d adc=%0d want 1 500 %0d", vis.size(), best_freq, best_adc, exp_ba); end
      release_start();
   endtask

   task automatic test_reset_mid();
      int cyc;
      bit to;
      prof_mode = 0; peak = 100200;
      cfg_start = 20'd100000; cfg_stop = 20'd100400; cfg_step = 20'd100; cfg_settle = 24'd4;
      fine_en = 1'b0; drive_valid = 1'b1; enable = 1'b1; start = 1'b1;
      cyc = 0;
      do begin @(posedge clk); #1; cyc++; end while (!(busy && freq_out == 20'd100100) && cyc < 5000);
      rst = 1'b1;
      @(posedge clk); #1;
      total++; if (freq_out !== 20'd0 || best_freq !== 20'd0 || best_adc !== 12'd0 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL midreset_outputs got freq=%0d best=%0d adc=%0d busy=%b done=%b want all 0", freq_out, best_freq, best_adc, busy, done); end
      rst = 1'b0;
      model_sweep(100000, 100400, 100, 1'b0);
      run_sweep(100000, 100400, 100, 4, 1'b0, 1'b0, to);
      total++; if (to || best_freq !== 20'd100200 || best_adc !== 12'd3000 || seq_diff() != 0) begin bad++; $display("FAIL midreset_rerun got best=%0d adc=%0d pts=%0d timeout=%b want 100200 3000 5", best_freq, best_adc, vis.size(), to); end
      release_start();
   endtask

   task automatic test_random();
      bit     to, fine, scr;
      longint st, sp, stp;
      prof_mode = 2;
      for (int it = 0; it < 6; it++) begin
         seed = $urandom;
         st   = $urandom_range(0, 20'hF0000);
         sp   = st + $urandom_range(0, 2500);
         if ($urandom_range(0, 7) == 0 && st > 100) sp = st - $urandom_range(1, 100);
         stp  = $urandom_range(30, 300);
         fine = 1'($urandom_range(0, 1));
         scr  = 1'($urandom_range(0, 1));
         model_sweep(st, sp, stp, fine);
         run_sweep(st, sp, stp, $urandom_range(0, 3), fine, scr, to);
         // Restore the original request so the release check has a known start value.
         cfg_start = FREQ_W'(st);
         total++; if (to || longint'(best_freq) != exp_bf || int'(best_adc) != exp_ba) begin bad++; $display("FAIL random_best it=%0d got %0d/%0d want %0d/%0d timeout=%b", it, best_freq, best_adc, exp_bf, exp_ba, to); end
         total++; if (seq_diff() != 0) begin bad++; $display("FAIL random_points it=%0d got=%0d want=%0d diff=%0d", it, vis.size(), exp_pts.size(), seq_diff()); end
         release_start();
         total++; if (done !== 1'b0 || longint'(freq_out) != st) begin bad++; $display("FAIL random_release it=%0d got done=%b freq=%0d want 0 %0d", it, done, freq_out, st); end
      end
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; start = 1'b0; fine_en = 1'b0;
      adc = '0; adc_valid = 1'b0;
      cfg_start = '0; cfg_stop = '0; cfg_step = '0; cfg_settle = '0;
      test_reset();
      test_coarse();
      test_fine();
      test_tie();
      test_abort();
      test_boundaries();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/freq_sweep.md
FREQ_SWEEP -- requirements
Module: freq_sweep

Interface
REQ-001 Parameter FREQ_W, 20, width of frequency words.
REQ-002 Parameter ADC_W, 12, width of ADC sample.
REQ-003 Parameter SETTLE_W, 24, width of settle-time counter.
REQ-004 Parameter AVG_LOG2, 2, log2 of ADC samples averaged per frequency point (0..6).
REQ-005 Parameter FINE_SHIFT, 3, right-shift applied to cfg_step for fine pass.
REQ-006 Ports: clk in 1 system clock; rst in 1 reset; one clock, and reset is synchronous and active-high.
REQ-007 Ports: enable in 1 link alive (swipt active); start in 1 level request to run sweep; fine_en in 1 enable fine refinement pass.
REQ-008 Ports: adc in ADC_W rectified-power sample; adc_valid in 1 sample strobe.
REQ-009 Ports: cfg_start in FREQ_W; cfg_stop in FREQ_W; cfg_step in FREQ_W; cfg_settle in SETTLE_W.
REQ-010 Ports: freq_out out FREQ_W drive frequency; best_freq out FREQ_W; best_adc out ADC_W; busy out 1; done out 1.

Function
REQ-011 FSM states SHALL be IDLE, SETTLE, ACCUM, EVAL, FINE_SETUP, DONE.
REQ-012 IDLE: freq_out = cfg_start, busy = 0; on start = 1 with enable = 1, the block SHALL latch cfg_* into working registers, clear best_adc to 0, set best_freq = cfg_start, load the settle counter, and enter SETTLE next cycle.
REQ-013 SETTLE SHALL count down cfg_settle cycles (cfg_settle = 0 means one cycle), ignoring adc_valid, then enter ACCUM with accumulator and sample count cleared.
REQ-014 ACCUM SHALL add adc to a (ADC_W+AVG_LOG2)-bit accumulator on each adc_valid cycle and enter EVAL after the 2^AVG_LOG2-th valid sample is added.
REQ-015 EVAL (one cycle): avg = accumulator >> AVG_LOG2; if avg > best_adc (strict, so ties keep the lower frequency), best_adc <= avg and best_freq <= freq_out.
REQ-016 EVAL next point: nxt = freq_out + step computed at FREQ_W+1 bits; if nxt <= stop, freq_out <= nxt and go to SETTLE; otherwise the pass ends.
REQ-017 At pass end: if this was the coarse pass, fine_en = 1 and step > 1, go to FINE_SETUP; otherwise go to DONE.
REQ-018 FINE_SETUP: lo = max(best_freq - step, cfg_start) with underflow clamped to cfg_start; hi = min(best_freq + step, cfg_stop) with overflow clamped; step <= max(step >> FINE_SHIFT, 1); freq_out <= lo; then SETTLE. best_* SHALL be retained.
REQ-019 DONE: done = 1, busy = 0, freq_out = best_freq; hold until start = 0, then go to IDLE (done clears in the same transition).
REQ-020 busy SHALL be 1 in SETTLE, ACCUM, EVAL and FINE_SETUP.
REQ-021 cfg_step = 0 SHALL be treated as 1; cfg_stop < cfg_start SHALL evaluate the cfg_start point only, then end the pass.
REQ-022 enable = 0 in any state SHALL force IDLE next cycle: done = 0, busy = 0; best_freq and best_adc are retained; freq_out = cfg_start.
REQ-023 start falling while busy SHALL abort to IDLE the same way as REQ-022.
REQ-024 cfg_* changes while busy SHALL have no effect until the next start.

Reset
REQ-025 rst = 1 at a clk edge SHALL set state IDLE, freq_out = 0, best_freq = 0, best_adc = 0, busy = 0, done = 0, and clear all counters and accumulators.
REQ-026 rst SHALL override enable and start.

Structure
REQ-027 State encoding and default parameter constants SHALL live in package freq_pkg, shared with the SWIPT control blocks.
REQ-028 Averaging SHALL be one sub-module, adc_avg (accumulate, count, avg_valid pulse), instantiated once.
REQ-029 There SHALL be no combinational path from adc to any output.

Verification
REQ-030 Coarse sweep: start 100000, stop 100400, step 100, settle 4, AVG_LOG2 2, constant ADC per point with a peak of 3000 at 100200 -> done; best_freq 100200; best_adc 3000; five points visited.
REQ-031 Fine pass: same stimulus, fine_en 1, true peak 100237, FINE_SHIFT 3 -> fine range 100100..100300, step 12, best_freq 100232 (nearest grid point at or below the peak on ties).
REQ-032 Tie: equal ADC 2000 at 100100 and 100300 -> best_freq 100100.
REQ-033 Abort: enable dropped during ACCUM of the 3rd point -> IDLE next cycle; busy 0; done 0; best_* hold values from point 2.
REQ-034 Boundaries: cfg_step 0 -> step 1 used; stop 0xFFFFF with step 0x80000 -> no wrap, sweep ends at the last point not greater than stop.
REQ-035 Reset mid-SETTLE -> all outputs at REQ-025 values next cycle; a new start runs a full sweep.
